// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor PWM drive: FSM state encoding,
// PWM geometry constants and the saturating wheel-duty mixer.
package motor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam int unsigned PWM_MAX    = 15;
    localparam int unsigned PWM_PERIOD = 15;

    // speed + off, evaluated 7-bit signed, clamped to 0..PWM_MAX
    function automatic logic [3:0] mix_sat(input logic [3:0] speed,
                                           input logic signed [5:0] off);
        logic signed [6:0] sum;
        sum = signed'({3'b000, speed}) + signed'({off[5], off});
        if (sum < 7'sd0)
            mix_sat = 4'd0;
        else if (sum > signed'(7'(PWM_MAX)))
            mix_sat = 4'(PWM_MAX);
        else
            mix_sat = sum[3:0];
    endfunction

endpackage

// File: rtl/motor_mix.sv
// Differential-steering mixer: converts speed/direction into saturated
// left and right wheel duties. Purely combinational.
module motor_mix
    import motor_pkg::*;
#(
    parameter int unsigned DIR_CENTER = 8
) (
    input  logic [3:0] speed,
    input  logic [3:0] dir,
    output logic [3:0] duty_l,
    output logic [3:0] duty_r
);

    logic signed [5:0] off;

    assign off    = signed'({2'b00, dir}) - signed'(6'(DIR_CENTER));
    assign duty_l = mix_sat(speed, off);
    assign duty_r = mix_sat(speed, -off);

endmodule

// File: rtl/motor_pwm_drive.sv
// Two-channel motor PWM drive with period-boundary duty shadowing.
// Optional command watchdog enabled by defining MOTOR_PWM_WATCHDOG_EN.
module motor_pwm_drive
    import motor_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned DIR_CENTER  = 8,
    parameter int unsigned WDT_PERIODS = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] speed,
    input  logic [3:0] dir,
    input  logic       cmd_valid,
    output logic       pwm_l,
    output logic       pwm_r,
    output logic       period_start,
    output logic       fault,
    output logic [1:0] state
);

    state_t      state_q, state_next;
    logic [15:0] presc;
    logic [3:0]  cnt;
    logic [3:0]  act_l, act_r;
    logic [3:0]  duty_l, duty_r;
    logic        tick, period_end, run_stay, wdt_expire;

    motor_mix #(.DIR_CENTER(DIR_CENTER)) u_mix (
        .speed  (speed),
        .dir    (dir),
        .duty_l (duty_l),
        .duty_r (duty_r)
    );

    assign tick       = (presc == 16'(CLK_DIV - 1));
    assign period_end = tick && (cnt == 4'(PWM_PERIOD - 1));
    assign run_stay   = (state_q == ST_RUN) && (state_next == ST_RUN);
    assign state      = state_q;

`ifdef MOTOR_PWM_WATCHDOG_EN
    logic [7:0] wdt;

    // cmd_valid beats a same-cycle period end, so the clear takes priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wdt <= '0;
        else if (state_q != ST_RUN || cmd_valid)
            wdt <= '0;
        else if (period_end)
            wdt <= wdt + 8'd1;
    end

    assign wdt_expire = (state_q == ST_RUN) && period_end && !cmd_valid &&
                        (wdt == 8'(WDT_PERIODS - 1));
    assign fault      = (state_q == ST_FAULT);
`else
    logic unused_wdt;
    assign unused_wdt = ^{cmd_valid, 8'(WDT_PERIODS)};
    assign wdt_expire = 1'b0;
    assign fault      = 1'b0;
`endif

    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE:  if (en) state_next = ST_RUN;
            ST_RUN: begin
                if (!en)
                    state_next = ST_IDLE;
                else if (wdt_expire)
                    state_next = ST_FAULT;
            end
            ST_FAULT: if (!en) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs key off the next state so leaving RUN silences them on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            presc        <= '0;
            cnt          <= '0;
            act_l        <= '0;
            act_r        <= '0;
            pwm_l        <= 1'b0;
            pwm_r        <= 1'b0;
            period_start <= 1'b0;
        end else begin
            state_q <= state_next;
            if (run_stay) begin
                presc <= tick ? '0 : presc + 16'd1;
                if (tick)
                    cnt <= (cnt == 4'(PWM_PERIOD - 1)) ? '0 : cnt + 4'd1;
                if (period_end) begin
                    act_l <= duty_l;
                    act_r <= duty_r;
                end
            end else begin
                presc <= '0;
                cnt   <= '0;
                act_l <= '0;
                act_r <= '0;
            end
            pwm_l        <= (state_next == ST_RUN) && (cnt < act_l);
            pwm_r        <= (state_next == ST_RUN) && (cnt < act_r);
            period_start <= run_stay && period_end;
        end
    end

endmodule
